// File: rtl/i2s_tx_feeder_pkg.sv
// i2s_tx_feeder_pkg
// Shared definitions for the I2S transmit feeder: default sample width,
// default FIFO depth and the ceil-log2 helper also used by i2s_master to
// size pointers and counters.
package i2s_tx_feeder_pkg;

  localparam int DATA_WIDTH_DEF = 24;
  localparam int DEPTH_DEF      = 8;

  // Smallest r with 2**r >= n (0 for n <= 1).
  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/i2s_stereo_fifo.sv
// i2s_stereo_fifo
// Synchronous FIFO holding stereo pairs as single 2*DATA_WIDTH entries.
// Ports:
//   clk, arstn          clock, asynchronous active-low reset
//   flush_i             synchronous clear of pointers and occupancy
//   push_i, wdata_i     write an entry (ignored when full or flushing)
//   pop_i, rdata_o      rdata_o always shows the oldest entry; pop_i retires it
//   level_o             occupancy 0..DEPTH
//   empty_o, full_o     occupancy flags
module i2s_stereo_fifo
  import i2s_tx_feeder_pkg::*;
#(
  parameter int W     = 2 * DATA_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rdata_o,
  output logic [log2c(DEPTH):0]  level_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int AW = log2c(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;
  logic          push_ok;
  logic          pop_ok;

  assign empty_o = (level_q == LW'(0));
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = mem[rd_ptr_q];

  // Guard against overflow/underflow regardless of what the caller asks for.
  assign push_ok = push_i & ~full_o  & ~flush_i;
  assign pop_ok  = pop_i  & ~empty_o & ~flush_i;

  // Next-state for pointers and occupancy; pointers wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage: validity is tracked by occupancy only, so no reset here.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/i2s_tx_feeder.sv
// i2s_tx_feeder
// Buffers upstream stereo pairs and hands one pair per I2S frame to the
// I2S master. A new pair is loaded on each ws rising edge so left and right
// of the same pair are shifted out back to back.
// Ports:
//   clk, arstn                         clock, asynchronous active-low reset
//   enable                             0 flushes the FIFO and mutes outputs
//   in_valid, in_ready                 upstream handshake
//   in_left, in_right                  upstream sample pair
//   ws                                 word select from i2s_master
//   data_send_left, data_send_right    registered pair to i2s_master
//   level                              FIFO occupancy 0..DEPTH
//   underrun, underrun_clr             sticky empty-slot flag and its clear
module i2s_tx_feeder
  import i2s_tx_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   enable,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_left,
  input  logic [DATA_WIDTH-1:0]  in_right,
  input  logic                   ws,
  output logic [DATA_WIDTH-1:0]  data_send_left,
  output logic [DATA_WIDTH-1:0]  data_send_right,
  output logic [log2c(DEPTH):0]  level,
  output logic                   underrun,
  input  logic                   underrun_clr
);

  logic                    ws_q;
  logic                    tick;
  logic                    push;
  logic                    pop;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [2*DATA_WIDTH-1:0] fifo_rdata;
  logic [DATA_WIDTH-1:0]   left_q,  left_d;
  logic [DATA_WIDTH-1:0]   right_q, right_d;
  logic                    underrun_q, underrun_d;

  // ws_q resets to 1 so a ws held high across reset release is not a tick.
  assign tick = ws & ~ws_q;

  // in_ready uses the registered occupancy, so a pop never frees a slot in
  // the same cycle; arstn gating keeps it low throughout reset.
  assign in_ready = arstn & enable & ~fifo_full;
  assign push     = in_valid & in_ready;
  assign pop      = enable & tick & ~fifo_empty;

  i2s_stereo_fifo #(
    .W     (2 * DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .arstn   (arstn),
    .flush_i (~enable),
    .push_i  (push),
    .wdata_i ({in_left, in_right}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .level_o (level),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Output pair and underrun next-state; a set in the same cycle beats clear.
  always_comb begin
    left_d     = left_q;
    right_d    = right_q;
    underrun_d = underrun_q & ~underrun_clr;
    if (!enable) begin
      left_d  = '0;
      right_d = '0;
    end else if (tick) begin
      if (fifo_empty) begin
        left_d     = '0;
        right_d    = '0;
        underrun_d = 1'b1;
      end else begin
        left_d  = fifo_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
        right_d = fifo_rdata[DATA_WIDTH-1:0];
      end
    end else begin
      left_d  = left_q;
      right_d = right_q;
    end
  end

  // Word-select history, output pair and sticky underrun.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      ws_q       <= 1'b1;
      left_q     <= '0;
      right_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      ws_q       <= ws;
      left_q     <= left_d;
      right_q    <= right_d;
      underrun_q <= underrun_d;
    end
  end

  assign data_send_left  = left_q;
  assign data_send_right = right_q;
  assign underrun        = underrun_q;

endmodule

// File: tb/tb_i2s_tx_feeder.sv
// tb_i2s_tx_feeder
// Table-driven bench for i2s_tx_feeder (DEPTH=4, DATA_WIDTH=24). Each record
// gives one cycle of inputs plus expected in_ready (before the edge), level
// and underrun (after the edge). Accepted pairs go into a scoreboard queue
// and are popped on each expected frame tick to predict the output pair.
module tb_i2s_tx_feeder;

  localparam int DW    = 24;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          arstn = 1'b1;
  logic          enable = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_left = '0;
  logic [DW-1:0] in_right = '0;
  logic          ws = 1'b0;
  logic [DW-1:0] data_send_left;
  logic [DW-1:0] data_send_right;
  logic [2:0]    level;
  logic          underrun;
  logic          underrun_clr = 1'b0;

  always #5 clk = ~clk;

  i2s_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .arstn           (arstn),
    .enable          (enable),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_left         (in_left),
    .in_right        (in_right),
    .ws              (ws),
    .data_send_left  (data_send_left),
    .data_send_right (data_send_right),
    .level           (level),
    .underrun        (underrun),
    .underrun_clr    (underrun_clr)
  );

  typedef struct {
    logic          en;
    logic          v;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic          w;
    logic          clr;
    logic          rdy;
    logic [2:0]    lvl;
    logic          und;
  } vec_t;

  vec_t           tbl[$];
  logic [2*DW-1:0] sb[$];
  logic [DW-1:0]  exp_l = '0;
  logic [DW-1:0]  exp_r = '0;
  logic           tb_ws_q = 1'b1;
  int             n_chk = 0;
  int             n_pass = 0;

  function automatic vec_t mk(logic en, logic v, logic [DW-1:0] l, logic [DW-1:0] r,
                              logic w, logic clr, logic rdy, logic [2:0] lvl, logic und);
    vec_t s;
    s.en = en; s.v = v; s.l = l; s.r = r; s.w = w; s.clr = clr;
    s.rdy = rdy; s.lvl = lvl; s.und = und;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Entered and left at posedge+1; drives one cycle and checks it.
  task automatic step(input vec_t s, input string tag);
    logic            tick;
    logic [2*DW-1:0] p;
    enable = s.en; in_valid = s.v; in_left = s.l; in_right = s.r;
    ws = s.w; underrun_clr = s.clr;
    @(negedge clk);
    chk({tag, " in_ready"}, 32'(in_ready), 32'(s.rdy));
    @(posedge clk);
    tick = s.w & ~tb_ws_q;
    tb_ws_q = s.w;
    if (s.en) begin
      if (tick) begin
        if (sb.size() > 0) begin
          p = sb.pop_front();
          exp_l = p[2*DW-1:DW];
          exp_r = p[DW-1:0];
        end else begin
          exp_l = '0;
          exp_r = '0;
        end
      end
      if (s.v && s.rdy) sb.push_back({s.l, s.r});
    end else begin
      sb.delete();
      exp_l = '0;
      exp_r = '0;
    end
    #1;
    chk({tag, " level"},    32'(level),           32'(s.lvl));
    chk({tag, " underrun"}, 32'(underrun),        32'(s.und));
    chk({tag, " left"},     32'(data_send_left),  32'(exp_l));
    chk({tag, " right"},    32'(data_send_right), 32'(exp_r));
  endtask

  initial begin
    //                 en v  left         right        ws clr rdy lvl und
    // Two pairs, two frame ticks
    tbl.push_back(mk(1, 1, 24'h111111, 24'h222222, 0, 0, 1, 3'd1, 0));
    tbl.push_back(mk(1, 1, 24'h333333, 24'h444444, 0, 0, 1, 3'd2, 0));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      1, 0, 1, 3'd1, 0));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      0, 0, 1, 3'd1, 0));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      1, 0, 1, 3'd0, 0));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      0, 0, 1, 3'd0, 0));
    // Underrun set, clear, set-wins-over-clear
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      1, 0, 1, 3'd0, 1));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      0, 1, 1, 3'd0, 0));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      1, 1, 1, 3'd0, 1));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      0, 0, 1, 3'd0, 1));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      0, 1, 1, 3'd0, 0));
    // Fill to full with in_valid held; 5th waits for a tick
    tbl.push_back(mk(1, 1, 24'hA1A1A1, 24'h1A1A1A, 0, 0, 1, 3'd1, 0));
    tbl.push_back(mk(1, 1, 24'hA2A2A2, 24'h2A2A2A, 0, 0, 1, 3'd2, 0));
    tbl.push_back(mk(1, 1, 24'hA3A3A3, 24'h3A3A3A, 0, 0, 1, 3'd3, 0));
    tbl.push_back(mk(1, 1, 24'hA4A4A4, 24'h4A4A4A, 0, 0, 1, 3'd4, 0));
    tbl.push_back(mk(1, 1, 24'hA5A5A5, 24'h5A5A5A, 0, 0, 0, 3'd4, 0));
    tbl.push_back(mk(1, 1, 24'hA5A5A5, 24'h5A5A5A, 1, 0, 0, 3'd3, 0));
    tbl.push_back(mk(1, 1, 24'hA5A5A5, 24'h5A5A5A, 0, 0, 1, 3'd4, 0));
    // Drain to 2, then push and tick together; order preserved
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      1, 0, 0, 3'd3, 0));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      0, 0, 1, 3'd3, 0));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      1, 0, 1, 3'd2, 0));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      0, 0, 1, 3'd2, 0));
    tbl.push_back(mk(1, 1, 24'hB1B1B1, 24'h1B1B1B, 1, 0, 1, 3'd2, 0));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      0, 0, 1, 3'd2, 0));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      1, 0, 1, 3'd1, 0));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      0, 0, 1, 3'd1, 0));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      1, 0, 1, 3'd0, 0));
    // Level 3 then one disabled cycle (with ws rise and valid), re-enable
    tbl.push_back(mk(1, 1, 24'hC1C1C1, 24'h1C1C1C, 0, 0, 1, 3'd1, 0));
    tbl.push_back(mk(1, 1, 24'hC2C2C2, 24'h2C2C2C, 0, 0, 1, 3'd2, 0));
    tbl.push_back(mk(1, 1, 24'hC3C3C3, 24'h3C3C3C, 0, 0, 1, 3'd3, 0));
    tbl.push_back(mk(0, 1, 24'hC4C4C4, 24'h4C4C4C, 1, 0, 0, 3'd0, 0));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      0, 0, 1, 3'd0, 0));
    tbl.push_back(mk(1, 1, 24'hABCDEF, 24'h123456, 0, 0, 1, 3'd1, 0));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      1, 0, 1, 3'd0, 0));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      0, 0, 1, 3'd0, 0));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      1, 0, 1, 3'd0, 1));
    tbl.push_back(mk(1, 0, 24'h0,      24'h0,      0, 0, 1, 3'd0, 1));

    // Power-on reset, enable held high: in_ready must still be low.
    #1 arstn = 1'b0;
    #2;
    chk("rst in_ready", 32'(in_ready),        32'd0);
    chk("rst level",    32'(level),           32'd0);
    chk("rst underrun", 32'(underrun),        32'd0);
    chk("rst left",     32'(data_send_left),  32'd0);
    chk("rst right",    32'(data_send_right), 32'd0);
    @(posedge clk);
    #1 arstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("row%0d", i));
    end

    // Mid-stream reset at level 3 with underrun set and outputs non-zero.
    step(mk(1, 1, 24'hD1D1D1, 24'h1D1D1D, 0, 0, 1, 3'd1, 1), "d1");
    step(mk(1, 1, 24'hD2D2D2, 24'h2D2D2D, 0, 0, 1, 3'd2, 1), "d2");
    step(mk(1, 1, 24'hD3D3D3, 24'h3D3D3D, 0, 0, 1, 3'd3, 1), "d3");
    step(mk(1, 1, 24'hD4D4D4, 24'h4D4D4D, 0, 0, 1, 3'd4, 1), "d4");
    step(mk(1, 0, 24'h0,      24'h0,      1, 0, 0, 3'd3, 1), "d_tick");
    in_valid = 1'b0;
    arstn = 1'b0;
    #1;
    chk("mid_rst in_ready", 32'(in_ready),        32'd0);
    chk("mid_rst level",    32'(level),           32'd0);
    chk("mid_rst underrun", 32'(underrun),        32'd0);
    chk("mid_rst left",     32'(data_send_left),  32'd0);
    chk("mid_rst right",    32'(data_send_right), 32'd0);
    sb.delete();
    exp_l = '0;
    exp_r = '0;
    tb_ws_q = 1'b1;
    @(posedge clk);
    #1 arstn = 1'b1;
    // ws still high on release: no tick, so no underrun.
    step(mk(1, 0, 24'h0,      24'h0,      1, 0, 1, 3'd0, 0), "rel_ws1");
    step(mk(1, 0, 24'h0,      24'h0,      0, 0, 1, 3'd0, 0), "rel_ws0");
    step(mk(1, 0, 24'h0,      24'h0,      1, 0, 1, 3'd0, 1), "rel_tick");
    step(mk(1, 1, 24'hE1E1E1, 24'h1E1E1E, 0, 0, 1, 3'd1, 1), "e_push");
    step(mk(1, 0, 24'h0,      24'h0,      1, 0, 1, 3'd0, 1), "e_tick");
    step(mk(1, 0, 24'h0,      24'h0,      0, 1, 1, 3'd0, 0), "e_clr");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
